// File: rtl/inet_csum_stream_pkg.sv
// Shared types and helpers for the streamed RFC 1071 ones'-complement checksum engine.
package inet_csum_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FOLD1,
        ST_FOLD2,
        ST_DONE
    } state_t;

    // Folded sum value that marks a window whose embedded checksum verifies.
    localparam logic [15:0] CSUM_OK_VAL = 16'hFFFF;

    // Widest accumulator the fold helper supports; callers zero-extend into it.
    localparam int FOLD_W = 64;

    // One end-around-carry step: low 16 bits plus everything above them.
    function automatic logic [FOLD_W-1:0] fold(input logic [FOLD_W-1:0] v);
        return {48'd0, v[15:0]} + {16'd0, v[FOLD_W-1:16]};
    endfunction

endpackage

// File: rtl/inet_csum_stream_if.sv
// Command, beat-stream and result signals of inet_csum_stream, bundled with master/slave views.
interface inet_csum_stream_if #(
    parameter int BYTES_PER_BEAT = 2,
    parameter int POS_WIDTH      = 16
);
    logic                        start;
    logic                        start_ready;
    logic [POS_WIDTH-1:0]        start_off;
    logic [POS_WIDTH-1:0]        start_len;
    logic [31:0]                 start_seed;
    logic [8*BYTES_PER_BEAT-1:0] in_data;
    logic                        in_valid;
    logic                        in_last;
    logic                        in_ready;
    logic [15:0]                 csum;
    logic                        csum_ok;
    logic                        err_short;
    logic                        csum_valid;
    logic                        busy;

    modport master (
        output start, start_off, start_len, start_seed, in_data, in_valid, in_last,
        input  start_ready, in_ready, csum, csum_ok, err_short, csum_valid, busy
    );

    modport slave (
        input  start, start_off, start_len, start_seed, in_data, in_valid, in_last,
        output start_ready, in_ready, csum, csum_ok, err_short, csum_valid, busy
    );
endinterface

// File: rtl/inet_csum_stream_beat_terms.sv
// Per-beat partial sum: masks bytes outside the window and places each byte in the
// high or low half of its 16-bit word according to its offset inside the window.
module csum_beat_terms #(
    parameter int BYTES_PER_BEAT = 2,
    parameter int ACC_WIDTH      = 32,
    parameter int POS_WIDTH      = 16
) (
    input  logic [8*BYTES_PER_BEAT-1:0] data,
    input  logic [POS_WIDTH-1:0]        pos,
    input  logic [POS_WIDTH-1:0]        off,
    input  logic [POS_WIDTH-1:0]        len,
    output logic [ACC_WIDTH-1:0]        sum
);
    // One extra bit so pos+j and off+len never wrap.
    localparam int PW = POS_WIDTH + 1;

    logic [PW-1:0] win_end;

    assign win_end = PW'(off) + PW'(len);

    always_comb begin
        logic [PW-1:0] p;
        logic [PW-1:0] rel;
        logic [7:0]    b;
        // NOTE: every variable written here gets a value before any branch, so no latch can be inferred.
        sum = '0;
        p   = '0;
        rel = '0;
        b   = '0;
        for (int j = 0; j < BYTES_PER_BEAT; j++) begin
            p   = PW'(pos) + PW'(j);
            rel = p - PW'(off);
            b   = data[8*j +: 8];
            // Even window offset is the big-endian high byte; an odd tail byte pairs with an implicit zero.
            if (p >= PW'(off) && p < win_end)
                sum = sum + (rel[0] ? ACC_WIDTH'(b) : ACC_WIDTH'({b, 8'h00}));
        end
    end

endmodule

// File: rtl/inet_csum_stream.sv
// Streamed RFC 1071 checksum engine: sums a byte window of a frame onto a seed,
// folds twice and reports the complemented checksum three cycles after the last beat.
module inet_csum_stream
    import inet_csum_pkg::*;
#(
    parameter int BYTES_PER_BEAT = 2,   // 1, 2, 4 or 8
    parameter int ACC_WIDTH      = 32,  // 32 .. FOLD_W
    parameter int POS_WIDTH      = 16
) (
    input  logic clk,
    input  logic rst,
    inet_csum_stream_if.slave bus
);
    localparam int PW = POS_WIDTH + 1;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic [POS_WIDTH-1:0]   pos_q;
    logic [POS_WIDTH-1:0]   off_q;
    logic [POS_WIDTH-1:0]   len_q;
    logic [15:0]            csum_q;
    logic                   csum_ok_q;
    logic                   err_short_q;

    logic                   beat_xfer;
    logic [ACC_WIDTH-1:0]   beat_sum;
    logic [ACC_WIDTH-1:0]   fold_acc;
    logic [PW-1:0]          win_end;
    logic [PW-1:0]          pos_end;
    logic [POS_WIDTH-1:0]   pos_next;

    csum_beat_terms #(
        .BYTES_PER_BEAT (BYTES_PER_BEAT),
        .ACC_WIDTH      (ACC_WIDTH),
        .POS_WIDTH      (POS_WIDTH)
    ) u_terms (
        .data (bus.in_data),
        .pos  (pos_q),
        .off  (off_q),
        .len  (len_q),
        .sum  (beat_sum)
    );

    assign beat_xfer = (state_q == ST_ACCUM) && bus.in_valid;
    assign fold_acc  = ACC_WIDTH'(fold(FOLD_W'(acc_q)));
    assign win_end   = PW'(off_q) + PW'(len_q);
    assign pos_end   = PW'(pos_q) + PW'(BYTES_PER_BEAT);
    // Position saturates so a very long frame cannot wrap back into the window.
    assign pos_next  = pos_end[PW-1] ? '1 : pos_end[POS_WIDTH-1:0];

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.start)                  state_d = ST_ACCUM;
            ST_ACCUM: if (beat_xfer && bus.in_last)   state_d = ST_FOLD1;
            ST_FOLD1:                                 state_d = ST_FOLD2;
            ST_FOLD2:                                 state_d = ST_DONE;
            ST_DONE:                                  state_d = ST_IDLE;
            default:                                  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            pos_q       <= '0;
            off_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            csum_ok_q   <= 1'b0;
            err_short_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        off_q       <= bus.start_off;
                        len_q       <= bus.start_len;
                        acc_q       <= ACC_WIDTH'(bus.start_seed[15:0]) + ACC_WIDTH'(bus.start_seed[31:16]);
                        pos_q       <= '0;
                        csum_ok_q   <= 1'b0;
                        err_short_q <= 1'b0;
                    end
                end
                ST_ACCUM: begin
                    if (beat_xfer) begin
                        acc_q <= acc_q + beat_sum;
                        pos_q <= pos_next;
                        if (bus.in_last)
                            err_short_q <= (len_q != '0) && (win_end > pos_end);
                    end
                end
                ST_FOLD1: acc_q <= fold_acc;
                ST_FOLD2: begin
                    // Publish the result here so csum/csum_ok are already stable while csum_valid is high.
                    acc_q     <= fold_acc;
                    csum_q    <= ~fold_acc[15:0];
                    csum_ok_q <= (fold_acc[15:0] == CSUM_OK_VAL);
                end
                default: ;
            endcase
        end
    end

    assign bus.start_ready = (state_q == ST_IDLE);
    assign bus.in_ready    = (state_q == ST_ACCUM);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.csum_valid  = (state_q == ST_DONE);
    assign bus.csum        = csum_q;
    assign bus.csum_ok     = csum_ok_q;
    assign bus.err_short   = err_short_q;

endmodule

// File: tb/tb_inet_csum_stream.sv
// Scoreboard bench for inet_csum_stream: directed RFC 1071 vectors plus randomized frames
// checked against a byte-level ones'-complement reference model.
module tb_inet_csum_stream;

    localparam int BPB = 4;
    localparam int PWD = 16;

    typedef byte unsigned bq_t[$];
    typedef struct {
        logic [15:0] csum;
        logic        ok;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inet_csum_stream_if #(.BYTES_PER_BEAT(BPB), .POS_WIDTH(PWD)) bus ();

    inet_csum_stream #(
        .BYTES_PER_BEAT (BPB),
        .ACC_WIDTH      (32),
        .POS_WIDTH      (PWD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [15:0] last_csum = 16'h0000;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Bytes of a hex literal, most significant (first on the wire) first.
    function automatic bq_t bytes_of(input logic [255:0] v, input int n);
        bq_t r;
        for (int k = 0; k < n; k++) r.push_back(v[8*(n-1-k) +: 8]);
        return r;
    endfunction

    // The last beat always carries BPB bytes, so the frame is zero-padded to a whole beat.
    function automatic bq_t pad_frame(input bq_t f);
        bq_t r;
        r = f;
        while (r.size() == 0 || (r.size() % BPB) != 0) r.push_back(8'h00);
        return r;
    endfunction

    // Reference: ones'-complement sum of big-endian words over the window, folded until it fits.
    function automatic logic [15:0] ref_sum(input bq_t fr, input int off, input int len, input logic [31:0] seed);
        longint s;
        int     a;
        longint hi, lo;
        s = longint'(seed[15:0]) + longint'(seed[31:16]);
        for (int k = 0; k < len; k += 2) begin
            a  = off + k;
            hi = (a < fr.size()) ? longint'(fr[a]) : 0;
            lo = (k + 1 < len && a + 1 < fr.size()) ? longint'(fr[a+1]) : 0;
            s += hi * 256 + lo;
        end
        while (s > 65535) s = (s & 65535) + (s >> 16);
        return 16'(s);
    endfunction

    // Drives one frame. abort_beat >= 0 pulses rst while that beat is presented and expects no result.
    task automatic run_frame(input bq_t fr_in, input int off, input int len, input logic [31:0] seed,
                             input logic [15:0] e_csum, input logic e_ok, input logic e_err,
                             input bit bubbles, input int abort_beat);
        bq_t                 fr;
        int                  w;
        int                  nbeats;
        logic [8*BPB-1:0]    d;
        exp_t                e;
        fr     = pad_frame(fr_in);
        nbeats = fr.size() / BPB;

        w = 0;
        while (!bus.start_ready && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (!bus.start_ready) begin
            check("start_ready_timeout", 0, 1);
            return;
        end

        bus.start      = 1'b1;
        bus.start_off  = PWD'(off);
        bus.start_len  = PWD'(len);
        bus.start_seed = seed;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("csum_hold", bus.csum, last_csum);
        check("busy_flags", {bus.busy, bus.start_ready, bus.in_ready}, 3'b101);

        for (int b = 0; b < nbeats; b++) begin
            while (bubbles && $urandom_range(0, 2) == 0) begin
                bus.in_valid   = 1'b0;
                bus.start      = $urandom_range(0, 1) == 1;
                bus.start_off  = PWD'($urandom);
                bus.start_len  = PWD'($urandom);
                bus.start_seed = $urandom;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            for (int j = 0; j < BPB; j++) d[8*j +: 8] = fr[b*BPB + j];
            bus.in_data  = d;
            bus.in_valid = 1'b1;
            bus.in_last  = (b == nbeats - 1);
            if (b == abort_beat) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst          = 1'b0;
                bus.in_valid = 1'b0;
                bus.in_last  = 1'b0;
                last_csum    = 16'h0000;
                check("abort_idle", {bus.busy, bus.start_ready}, 2'b01);
                return;
            end
            w = 0;
            while (!bus.in_ready && w < 50) begin
                @(posedge clk); #1; w++;
            end
            if (!bus.in_ready) begin
                check("in_ready_timeout", 0, 1);
                bus.in_valid = 1'b0;
                return;
            end
            if (bus.in_last) begin
                e.csum = e_csum;
                e.ok   = e_ok;
                e.err  = e_err;
                e.cyc  = cyc + 3;
                exp_q.push_back(e);
                last_csum = e_csum;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Random frame whose expectation comes from the reference model.
    task automatic run_random(input int abort_beat);
        bq_t         fr;
        bq_t         pf;
        int          nbytes, off, len;
        logic [31:0] seed;
        logic [15:0] s;
        nbytes = $urandom_range(1, 40);
        for (int k = 0; k < nbytes; k++) fr.push_back(8'($urandom));
        off  = $urandom_range(0, nbytes + 3);
        len  = $urandom_range(0, nbytes + 2);
        seed = $urandom;
        pf   = pad_frame(fr);
        s    = ref_sum(pf, off, len, seed);
        run_frame(fr, off, len, seed, ~s, s == 16'hFFFF,
                  (len != 0) && (off + len > pf.size()), 1'b1, abort_beat);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && bus.csum_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_csum_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("csum",        bus.csum,      e.csum);
                    check("csum_ok",     bus.csum_ok,   e.ok);
                    check("err_short",   bus.err_short, e.err);
                    check("valid_cycle", cyc,           e.cyc);
                end
            end
        end
    end

    initial begin : stimulus
        bq_t ip;
        bq_t ip_z;
        int  w;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.start_off  = '0;
        bus.start_len  = '0;
        bus.start_seed = '0;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.in_last    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_flags", {bus.busy, bus.start_ready, bus.in_ready, bus.csum_valid}, 4'b0100);
        check("rst_result", {bus.csum, bus.csum_ok, bus.err_short}, 18'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        ip = bytes_of(256'h4500007300004000401_1B861C0A80001C0A800C7, 20);
        run_frame(ip, 0, 20, 32'h0, 16'h0000, 1'b1, 1'b0, 1'b0, -1);

        ip_z = ip;
        ip_z[10] = 8'h00;
        ip_z[11] = 8'h00;
        run_frame(ip_z, 0, 20, 32'h0, 16'hB861, 1'b0, 1'b0, 1'b1, -1);

        run_frame(bytes_of(256'h010203, 3), 0, 3, 32'h0, 16'hFBFD, 1'b0, 1'b0, 1'b0, -1);
        run_frame(bytes_of(256'hAA01020304, 5), 1, 4, 32'h0, 16'hFBF9, 1'b0, 1'b0, 1'b0, -1);
        run_frame(bytes_of(256'h112233445566, 6), 0, 10, 32'h0, 16'h6633, 1'b0, 1'b1, 1'b0, -1);
        run_frame(bytes_of(256'h0, 4), 0, 0, 32'h0001FFFF, 16'hFFFE, 1'b0, 1'b0, 1'b0, -1);
        run_frame(bytes_of(256'h0, 8), 0, 8, 32'h0, 16'hFFFF, 1'b0, 1'b0, 1'b1, -1);
        run_frame(bytes_of(256'h12345678, 4), 6, 2, 32'h0, 16'hFFFF, 1'b0, 1'b1, 1'b0, -1);

        for (int i = 0; i < 40; i++) begin
            if (i == 7 || i == 23) run_random($urandom_range(0, 1));
            else                   run_random(-1);
        end

        w = 0;
        while (exp_q.size() != 0 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        check("drain_pending", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
